// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that time-shares one combinational
// ALU between NUM_REQ requesters. A request is accepted in IDLE, executed for
// one cycle in EXEC, and its result is offered in RESP until consumed.
module alu_share_arbiter #(
  parameter int WIDTH        = 32,
  parameter int OPCODE_WIDTH = 2,
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0] req_opcode,
  input  logic [NUM_REQ*WIDTH-1:0]        req_op1,
  input  logic [NUM_REQ*WIDTH-1:0]        req_op2,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [WIDTH-1:0]                rsp_result,
  output logic [OPCODE_WIDTH-1:0]         alu_opcode,
  output logic [WIDTH-1:0]                alu_op1,
  output logic [WIDTH-1:0]                alu_op2,
  input  logic [WIDTH-1:0]                alu_result,
  output logic                            busy
);

  localparam int IW1 = ID_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [ID_W-1:0]         rr_ptr_r;
  logic [ID_W-1:0]         id_r;
  logic [OPCODE_WIDTH-1:0] opcode_r;
  logic [WIDTH-1:0]        op1_r;
  logic [WIDTH-1:0]        op2_r;
  logic [WIDTH-1:0]        result_r;

  logic                    found_s;
  logic [ID_W-1:0]         grant_idx_s;
  logic [IW1-1:0]          idx_v;
  logic                    accept_s;
  logic                    rsp_hs_s;
  logic [ID_W-1:0]         ptr_next_s;
  logic [OPCODE_WIDTH-1:0] gr_opcode_s;
  logic [WIDTH-1:0]        gr_op1_s;
  logic [WIDTH-1:0]        gr_op2_s;

  // Payload of the requester currently selected by the round-robin search.
  assign gr_opcode_s = req_opcode[grant_idx_s*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign gr_op1_s    = req_op1[grant_idx_s*WIDTH +: WIDTH];
  assign gr_op2_s    = req_op2[grant_idx_s*WIDTH +: WIDTH];

  assign accept_s = (state_r == ST_IDLE) && found_s;
  assign rsp_hs_s = (state_r == ST_RESP) && rsp_ready;

  // ALU and response ports always mirror the internal registers.
  assign alu_opcode = opcode_r;
  assign alu_op1    = op1_r;
  assign alu_op2    = op2_r;
  assign rsp_id     = id_r;
  assign rsp_result = result_r;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    idx_v       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = {1'b0, rr_ptr_r} + IW1'(k);
      if (idx_v >= IW1'(NUM_REQ)) begin
        idx_v = idx_v - IW1'(NUM_REQ);
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && req_valid[idx_v[ID_W-1:0]]) begin
        found_s     = 1'b1;
        grant_idx_s = idx_v[ID_W-1:0];
      end else begin
        found_s     = found_s;
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Pointer advances to the requester after the one just served.
  always_comb begin
    if (id_r == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = id_r + ID_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) state_nx_s = ST_EXEC;
        else         state_nx_s = ST_IDLE;
      end
      ST_EXEC: state_nx_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_RESP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs; req_ready is also masked while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s && rst_n) req_ready[grant_idx_s] = 1'b1;
        else                  req_ready = '0;
      end
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Operand and owner registers load only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_r <= '0;
      op1_r    <= '0;
      op2_r    <= '0;
      id_r     <= '0;
    end else if (accept_s) begin
      opcode_r <= gr_opcode_s;
      op1_r    <= gr_op1_s;
      op2_r    <= gr_op2_s;
      id_r     <= grant_idx_s;
    end
  end

  // Capture the ALU output at the end of the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '0;
    end else if (state_r == ST_EXEC) begin
      result_r <= alu_result;
    end
  end

  // Round-robin pointer moves only when a response is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (rsp_hs_s) begin
      rr_ptr_r <= ptr_next_s;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, corner
// sequences and randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int OW = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*OW-1:0]  req_opcode;
  logic [NR*W-1:0]   req_op1;
  logic [NR*W-1:0]   req_op2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_result;
  logic [OW-1:0]     alu_opcode;
  logic [W-1:0]      alu_op1;
  logic [W-1:0]      alu_op2;
  logic [W-1:0]      alu_result;
  logic              busy;

  int checks = 0;
  int fails  = 0;
  int mptr   = 0;

  // Bench-side view of every requester.
  logic [NR-1:0] v_a;
  logic [1:0]    op_a [NR];
  logic [31:0]   a_a  [NR];
  logic [31:0]   b_a  [NR];

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  alu_share_arbiter #(.WIDTH(W), .OPCODE_WIDTH(OW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .busy(busy)
  );

  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return ~(a & b);
    endcase
  endfunction

  // Shared ALU stand-in.
  assign alu_result = alu_f(alu_opcode, alu_op1, alu_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = v_a[i];
      if (v_a[i]) begin
        req_opcode[i*OW +: OW] = op_a[i];
        req_op1[i*W +: W]      = a_a[i];
        req_op2[i*W +: W]      = b_a[i];
      end else begin
        req_opcode[i*OW +: OW] = 2'($urandom_range(3, 0));
        req_op1[i*W +: W]      = $urandom;
        req_op2[i*W +: W]      = $urandom;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    v_a[i]  = 1'b1;
    op_a[i] = op;
    a_a[i]  = a;
    b_a[i]  = b;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(4, 0))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_alu_opcode"}, 64'(alu_opcode), 64'd0);
    chk({tag, "_alu_op1"}, 64'(alu_op1), 64'd0);
    chk({tag, "_alu_op2"}, 64'(alu_op2), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  // One full operation from IDLE grant to response handshake.
  // mode 0: granted requester drops valid; 1: keeps same request; 2: random.
  task automatic run_txn(input int delay, input int mode, output int got_id, output logic [31:0] got_res);
    int          eg;
    logic [31:0] er;
    logic [1:0]  eop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [3:0]  onehot;
    got_id  = -1;
    got_res = 32'd0;
    #1;
    eg = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (mptr + k) % NR;
      if (eg < 0 && v_a[idx]) eg = idx;
    end
    if (eg < 0) begin
      checks++;
      fails++;
      $display("FAIL run_txn_setup: got no valid requester expected at least one");
      return;
    end
    eop    = op_a[eg];
    ea     = a_a[eg];
    eb     = b_a[eg];
    er     = alu_f(eop, ea, eb);
    onehot = 4'b0001 << eg;
    chk("idle_req_ready", 64'(req_ready), 64'(onehot));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("exec_req_ready", 64'(req_ready), 64'd0);
    chk("exec_alu_opcode", 64'(alu_opcode), 64'(eop));
    chk("exec_alu_op1", 64'(alu_op1), 64'(ea));
    chk("exec_alu_op2", 64'(alu_op2), 64'(eb));
    if (mode == 0) begin
      v_a[eg] = 1'b0;
    end else if (mode == 2) begin
      if ($urandom_range(1, 0) == 0) v_a[eg] = 1'b0;
      else set_req(eg, 2'($urandom_range(3, 0)), rnd_operand(), rnd_operand());
      for (int i = 0; i < NR; i++) begin
        if (i != eg && v_a[i] && $urandom_range(7, 0) == 0) v_a[i] = 1'b0;
      end
    end
    apply();
    @(posedge clk); @(negedge clk);
    got_id  = int'(rsp_id);
    got_res = rsp_result;
    for (int c = 0; c <= delay; c++) begin
      chk("resp_valid", 64'(rsp_valid), 64'd1);
      chk("resp_id", 64'(rsp_id), 64'(eg));
      chk("resp_result", 64'(rsp_result), 64'(er));
      chk("resp_req_ready", 64'(req_ready), 64'd0);
      chk("resp_busy", 64'(busy), 64'd1);
      if (c < delay) begin
        @(posedge clk); @(negedge clk);
      end
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    mptr      = (eg + 1) % NR;
    #1;
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_alu_hold_op1", 64'(alu_op1), 64'(ea));
    chk("post_alu_hold_opcode", 64'(alu_opcode), 64'(eop));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          gid;
    logic [31:0] gres;
    int          exp_id4  [4];
    logic [31:0] exp_res4 [4];

    tbl[0] = '{2, 2'd0, 32'd5,          32'd7,          32'd12};
    tbl[1] = '{1, 2'd1, 32'd0,          32'd1,          32'hFFFF_FFFF};
    tbl[2] = '{3, 2'd2, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
    tbl[3] = '{0, 2'd0, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
    tbl[4] = '{2, 2'd3, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_FFFF};
    tbl[5] = '{1, 2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    tbl[6] = '{3, 2'd1, 32'd5,          32'd9,          32'hFFFF_FFFC};
    tbl[7] = '{0, 2'd3, 32'd0,          32'd0,          32'hFFFF_FFFF};

    exp_id4  = '{0, 1, 2, 3};
    exp_res4 = '{32'd7, 32'd42, 32'hF0F0_FFFF, 32'd2};

    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    v_a        = 4'b0000;
    req_valid  = '0;
    req_opcode = '0;
    req_op1    = '0;
    req_op2    = '0;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 2'd0; a_a[i] = 32'd0; b_a[i] = 32'd0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk_zero_outs("por");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_zero_outs("idle_empty");

    // All four requesters valid at once: grants in index order.
    set_req(0, 2'd1, 32'd10, 32'd3);
    set_req(1, 2'd2, 32'd6, 32'd7);
    set_req(2, 2'd3, 32'hFFFF_0000, 32'h0F0F_0F0F);
    set_req(3, 2'd0, 32'd1, 32'd1);
    apply();
    for (int k = 0; k < 4; k++) begin
      run_txn(0, 0, gid, gres);
      chk("all4_id", 64'(gid), 64'(exp_id4[k]));
      chk("all4_result", 64'(gres), 64'(exp_res4[k]));
    end

    // Directed single-requester vectors.
    for (int t = 0; t < 8; t++) begin
      v_a = 4'b0000;
      set_req(tbl[t].id, tbl[t].op, tbl[t].a, tbl[t].b);
      apply();
      run_txn(0, 0, gid, gres);
      chk("vec_id", 64'(gid), 64'(tbl[t].id));
      chk("vec_result", 64'(gres), 64'(tbl[t].exp));
    end

    // Backpressure for 10 cycles with other requests pending.
    v_a = 4'b0000;
    set_req(1, 2'd0, 32'd100, 32'd23);
    set_req(2, 2'd2, 32'd9, 32'd9);
    apply();
    run_txn(10, 0, gid, gres);
    run_txn(0, 0, gid, gres);

    // Fairness between requesters 0 and 3, both continuously valid.
    do_reset();
    v_a = 4'b0000;
    set_req(0, 2'd0, 32'd11, 32'd22);
    set_req(3, 2'd1, 32'd50, 32'd8);
    apply();
    for (int k = 0; k < 8; k++) begin
      run_txn(0, 1, gid, gres);
      chk("fair_id", 64'(gid), (k % 2 == 1) ? 64'd3 : 64'd0);
    end

    // Reset while in EXEC aborts the operation and clears the pointer.
    v_a = 4'b0000;
    apply();
    @(negedge clk);
    set_req(1, 2'd0, 32'd1, 32'd2);
    apply();
    run_txn(0, 0, gid, gres);
    set_req(1, 2'd2, 32'd3, 32'd4);
    set_req(3, 2'd0, 32'hDEAD_0000, 32'h0000_BEEF);
    apply();
    #1;
    chk("abort_grant", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); @(negedge clk);
    chk("abort_in_exec", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero_outs("mid_exec");
    @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    mptr  = 0;
    #1;
    chk("abort_no_rsp_after", 64'(rsp_valid), 64'd0);
    run_txn(0, 0, gid, gres);
    chk("abort_first_id", 64'(gid), 64'd1);
    chk("abort_first_res", 64'(gres), 64'd12);
    run_txn(0, 0, gid, gres);
    chk("abort_second_id", 64'(gid), 64'd3);

    // Randomized traffic against the transaction model.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v_a[i] && $urandom_range(2, 0) == 0)
          set_req(i, 2'($urandom_range(3, 0)), rnd_operand(), rnd_operand());
      end
      if (v_a == 4'b0000) set_req($urandom_range(3, 0), 2'($urandom_range(3, 0)), rnd_operand(), rnd_operand());
      apply();
      run_txn($urandom_range(3, 0), 2, gid, gres);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
